// File: rtl/word_to_bit_serializer.sv
// Parallel-to-serial front end: accepts W-bit words on a valid/ready handshake
// and emits one bit per clock on new_bit, with a one-word holding buffer for gapless streaming.
module word_to_bit_serializer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         new_bit,
  output logic         out_valid,
  output logic         out_last,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [W-1:0]  sh;
  logic [W-1:0]  hold;
  logic          hold_valid;
  logic [CW-1:0] cnt;

  logic last_cnt;
  logic load_pt;
  logic accept;

  assign last_cnt = (cnt == LAST);
  // A new word may enter the shifter when idle or while its last bit is on the output.
  assign load_pt  = (state == IDLE) || last_cnt;
  assign accept   = in_valid && !hold_valid;

  assign in_ready  = !hold_valid;
  assign out_valid = (state == SHIFT);
  assign new_bit   = out_valid ? (MSB_FIRST ? sh[W-1] : sh[0]) : IDLE_BIT;
  assign out_last  = out_valid && last_cnt;
  assign busy      = out_valid || hold_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (load_pt) begin
      cnt <= '0;
      if (hold_valid) begin
        sh         <= hold;
        hold_valid <= 1'b0;
        state      <= SHIFT;
      end else if (accept) begin
        sh    <= in_data;
        state <= SHIFT;
      end else begin
        state <= IDLE;
      end
    end else begin
      sh  <= MSB_FIRST ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};
      cnt <= cnt + 1'b1;
      if (accept) begin
        hold       <= in_data;
        hold_valid <= 1'b1;
      end
    end
  end

endmodule
